// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multichannel
//  Brief    : Shared prescaler/period counter driving NUM_CH double-buffered
//             PWM channels, edge- or center-aligned.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multichannel #(
    parameter int  NUM_CH  = 16,
    parameter int  CNT_W   = 8,
    parameter int  PRESC_W = 11,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [CNT_W-1:0]   period,
    input  logic               center_mode,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic [NUM_CH-1:0]  polarity,
    input  logic               duty_wr,
    input  logic [CH_W-1:0]    duty_ch,
    input  logic [CNT_W-1:0]   duty_data,
    output logic [NUM_CH-1:0]  out,
    output logic               period_tick
);

    localparam logic [0:0] c_DIR_UP   = 1'b0;
    localparam logic [0:0] c_DIR_DOWN = 1'b1;

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [0:0]         r_dir;
    logic               r_mode_active;
    logic               r_period_tick;

    logic               w_tick;
    logic               w_boundary;
    logic [CNT_W-1:0]   w_top;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [0:0]         w_dir_next;

    // >= rather than == so a live decrease of prescale wraps immediately
    assign w_tick = (r_presc_cnt >= prescale);
    assign w_top  = period - CNT_W'(1);

    always_comb begin
        w_boundary = 1'b0;
        w_cnt_next = r_cnt;
        w_dir_next = r_dir;
        if (w_tick) begin
            if (!r_mode_active) begin
                if (r_cnt >= period) begin
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end else if (period == '0) begin
                // Degenerate center span: every tick closes a period
                w_boundary = 1'b1;
            end else if (r_dir == c_DIR_UP) begin
                if (r_cnt >= w_top) begin
                    w_dir_next = c_DIR_DOWN;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end else begin
                if (r_cnt == '0) begin
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            if (w_boundary) begin
                w_cnt_next = '0;
                w_dir_next = c_DIR_UP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc_cnt   <= '0;
            r_cnt         <= '0;
            r_dir         <= c_DIR_UP;
            r_mode_active <= 1'b0;
            r_period_tick <= 1'b0;
        end else begin
            r_presc_cnt   <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);
            r_cnt         <= w_cnt_next;
            r_dir         <= w_dir_next;
            r_period_tick <= w_boundary;
            if (w_boundary) begin
                r_mode_active <= center_mode;
            end
        end
    end

    assign period_tick = r_period_tick;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_shadow;
        logic [CNT_W-1:0] r_active;
        logic             r_out;
        logic             w_lvl;

        assign w_lvl = en_pwm[i] ? (r_cnt < r_active) : 1'b1;

        // Out-of-range channel indices never match any channel, so they are dropped
        always_ff @(posedge clk) begin
            if (rst) begin
                r_shadow <= '0;
                r_active <= '0;
                r_out    <= 1'b0;
            end else begin
                if (w_boundary) begin
                    r_active <= r_shadow;
                end
                if (duty_wr && (duty_ch == CH_W'(i))) begin
                    r_shadow <= duty_data;
                end
                r_out <= en_out[i] & (w_lvl ^ polarity[i]);
            end
        end

        assign out[i] = r_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multichannel.sv
`default_nettype none
// Testbench for pwm_multichannel: position-based reference model plus
// directed period measurements and randomized register activity.
module tb_pwm_multichannel;
    localparam int NUM_CH  = 5;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 11;
    localparam int CH_W    = $clog2(NUM_CH);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PRESC_W-1:0] prescale = '0;
    logic [CNT_W-1:0]   period = '0;
    logic               center_mode = 1'b0;
    logic [NUM_CH-1:0]  en_out = '0;
    logic [NUM_CH-1:0]  en_pwm = '0;
    logic [NUM_CH-1:0]  polarity = '0;
    logic               duty_wr = 1'b0;
    logic [CH_W-1:0]    duty_ch = '0;
    logic [CNT_W-1:0]   duty_data = '0;
    logic [NUM_CH-1:0]  out;
    logic               period_tick;

    always #5 clk = ~clk;

    pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .period(period),
        .center_mode(center_mode), .en_out(en_out), .en_pwm(en_pwm),
        .polarity(polarity), .duty_wr(duty_wr), .duty_ch(duty_ch),
        .duty_data(duty_data), .out(out), .period_tick(period_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position p within the current period, count derived from it
    int                m_q, m_p, m_cnt, m_per;
    bit                m_mode, m_tk, m_bnd;
    int                m_shadow [NUM_CH];
    int                m_active [NUM_CH];
    logic [NUM_CH-1:0] m_out  = '0;
    logic              m_tick = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q = 0; m_p = 0; m_cnt = 0; m_mode = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            m_out  = '0;
            m_tick = 1'b0;
        end else begin
            m_per = int'(period);
            for (int i = 0; i < NUM_CH; i++) begin
                m_out[i] = en_out[i] & (((en_pwm[i] == 1'b0) || (m_cnt < m_active[i])) ^ polarity[i]);
            end
            m_tk  = (m_q >= int'(prescale));
            m_q   = m_tk ? 0 : m_q + 1;
            m_bnd = 1'b0;
            if (m_tk) begin
                if (!m_mode) m_bnd = (m_p >= m_per);
                else         m_bnd = (m_per == 0) || (m_p >= 2 * m_per - 1);
                if (m_bnd) begin
                    for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
                    m_mode = center_mode;
                    m_p    = 0;
                end else begin
                    m_p = m_p + 1;
                end
                m_cnt = (m_mode && m_p >= m_per) ? (2 * m_per - 1 - m_p) : m_p;
            end
            if (duty_wr && int'(duty_ch) < NUM_CH) m_shadow[int'(duty_ch)] = int'(duty_data);
            m_tick = m_bnd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out", 64'(out), 64'(m_out));
            check("period_tick", 64'(period_tick), 64'(m_tick));
        end
    end

    task automatic write_duty(input int ch, input int val);
        duty_wr   = 1'b1;
        duty_ch   = CH_W'(ch);
        duty_data = CNT_W'(val);
        @(negedge clk);
        duty_wr   = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (period_tick !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tick: no period_tick within 400 cycles");
        end
    endtask

    // Counts out[0] highs and cycles from one period_tick to the next
    task automatic measure(input int wr_at, input int wr_val, input int per_at, input int per_val,
                           output int highs, output int len);
        wait_tick();
        highs = 0;
        len   = 0;
        do begin
            duty_wr = 1'b0;
            highs += int'(out[0] === 1'b1);
            len++;
            if (len == wr_at) begin
                duty_wr = 1'b1; duty_ch = '0; duty_data = CNT_W'(wr_val);
            end
            if (len == per_at) period = CNT_W'(per_val);
            @(negedge clk);
        end while (period_tick !== 1'b1 && len < 400);
        duty_wr = 1'b0;
    endtask

    task automatic measure2(output int highs, output int len);
        measure(-1, 0, -1, 0, highs, len);
        measure(-1, 0, -1, 0, highs, len);
    endtask

    int h, l;

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset_out", 64'(out), 64'd0);
        check("reset_tick", 64'(period_tick), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Edge mode, prescale 0, period 9
        period = 8'd9; en_out = '1; en_pwm = '1; polarity = '0;
        write_duty(0, 3); write_duty(1, 1); write_duty(2, 5);
        write_duty(3, 9); write_duty(4, 10);
        measure(-1, 0, -1, 0, h, l);
        check("edge_p9_highs", 64'(h), 64'd3);
        check("edge_p9_len", 64'(l), 64'd10);

        // Prescale 2, then a mid-period duty change
        prescale = 11'd2;
        measure(-1, 0, -1, 0, h, l);
        check("presc2_highs", 64'(h), 64'd9);
        check("presc2_len", 64'(l), 64'd30);
        measure(10, 5, -1, 0, h, l);
        check("midwr_old_highs", 64'(h), 64'd9);
        measure(-1, 0, -1, 0, h, l);
        check("midwr_new_highs", 64'(h), 64'd15);
        check("midwr_new_len", 64'(l), 64'd30);

        // Live period decrease at cnt=8
        prescale = 11'd0;
        measure(-1, 0, -1, 0, h, l);
        check("presc0_len", 64'(l), 64'd10);
        measure(-1, 0, 9, 4, h, l);
        check("live_wrap_len", 64'(l), 64'd9);
        check("live_wrap_highs", 64'(h), 64'd5);
        measure2(h, l);
        check("p4_len", 64'(l), 64'd5);
        check("p4_full_highs", 64'(h), 64'd5);

        // Duty bounds and static levels
        period = 8'd9;
        write_duty(0, 0);
        measure2(h, l);
        check("duty0_highs", 64'(h), 64'd0);
        write_duty(0, 10);
        measure2(h, l);
        check("duty10_highs", 64'(h), 64'd10);
        en_pwm[0] = 1'b0; polarity[0] = 1'b1;
        measure2(h, l);
        check("static_inv_highs", 64'(h), 64'd0);
        en_pwm[0] = 1'b1; polarity[0] = 1'b0; en_out[0] = 1'b0;
        measure2(h, l);
        check("en_out0_highs", 64'(h), 64'd0);
        en_out[0] = 1'b1;
        write_duty(0, 3);
        write_duty(7, 200);
        measure2(h, l);
        check("bad_ch_highs", 64'(h), 64'd3);

        // Center mode
        center_mode = 1'b1; period = 8'd4;
        write_duty(0, 2);
        measure2(h, l);
        check("center_len", 64'(l), 64'd8);
        check("center_highs", 64'(h), 64'd4);
        write_duty(0, 4);
        measure2(h, l);
        check("center_full_highs", 64'(h), 64'd8);

        // Mid-period reset
        center_mode = 1'b0; period = 8'd9;
        write_duty(0, 3);
        measure2(h, l);
        check("pre_rst_highs", 64'(h), 64'd3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out", 64'(out), 64'd0);
        check("rst_mid_tick", 64'(period_tick), 64'd0);
        rst = 1'b0;
        measure2(h, l);
        check("post_rst_highs", 64'(h), 64'd0);
        check("post_rst_len", 64'(l), 64'd10);
        write_duty(0, 3);
        measure2(h, l);
        check("rewrite_highs", 64'(h), 64'd3);

        // Randomized register activity checked by the model every cycle
        for (int c = 0; c < 8000; c++) begin
            duty_wr = 1'b0;
            rst     = 1'b0;
            if ($urandom_range(0, 199) == 0) prescale = PRESC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                en_out   = NUM_CH'($urandom);
                en_pwm   = NUM_CH'($urandom);
                polarity = NUM_CH'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                duty_wr   = 1'b1;
                duty_ch   = CH_W'($urandom_range(0, 7));
                duty_data = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 14));
            end
            if (m_tick && $urandom_range(0, 2) == 0) begin
                period      = CNT_W'($urandom_range(0, 12));
                center_mode = 1'($urandom);
            end
            if ($urandom_range(0, 1499) == 0) rst = 1'b1;
            @(negedge clk);
        end
        duty_wr = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
